// File: rtl/vga_timing_monitor.sv
// Receive-side timing checker for a vga_if stream: measures line/frame periods and sync widths,
// reports lock and sticky errors. Define VGA_MON_CNT_CHECK_EN to also check hcount/vcount continuity.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 1344,
    parameter int H_SYNC_W    = 136,
    parameter int V_TOTAL     = 806,
    parameter int V_SYNC_W    = 6,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic        clr,
    output logic        locked,
    output logic        err_hlen,
    output logic        err_hsw,
    output logic        err_vlen,
    output logic        err_vsw,
    output logic        err_cnt,
    output logic [10:0] meas_h_total,
    output logic [10:0] meas_v_total,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] HT     = 11'(H_TOTAL);
    localparam logic [10:0] HSW    = 11'(H_SYNC_W);
    localparam logic [10:0] VT     = 11'(V_TOTAL);
    localparam logic [10:0] VSW    = 11'(V_SYNC_W);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [10:0] SAT    = 11'h7ff;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_n;
    logic [3:0]  good_cnt, good_n;
    logic        hs_q, vs_q, hs_rise, hs_fall, vs_rise, vs_fall, active;
    logic [10:0] h_meas, hsw, v_meas, vsw, v_next;
    logic        h_armed, frame_err;
    logic        hlen_det, hsw_det, vlen_det, vsw_det, cnt_det, any_err;

    function automatic logic [10:0] sat_inc(input logic [10:0] x);
        return (x == SAT) ? x : x + 11'd1;
    endfunction

    // A saturated counter can never match, even if a parameter is 2047.
    function automatic logic mism(input logic [10:0] x, input logic [10:0] exp);
        return (x != exp) || (x == SAT);
    endfunction

    assign hs_rise = hsync & ~hs_q;
    assign hs_fall = ~hsync & hs_q;
    assign vs_rise = vsync & ~vs_q;
    assign vs_fall = ~vsync & vs_q;
    assign active  = (state != SEARCH);
    // A coincident hsync rise belongs to the frame that is ending.
    assign v_next  = hs_rise ? sat_inc(v_meas) : v_meas;

    assign hlen_det = active && h_armed && hs_rise && mism(h_meas, HT);
    assign hsw_det  = active && h_armed && hs_fall && mism(hsw, HSW);
    assign vlen_det = active && vs_rise && mism(v_next, VT);
    assign vsw_det  = active && vs_fall && mism(vsw, VSW);
    assign any_err  = hlen_det | hsw_det | vlen_det | vsw_det | cnt_det;
    assign locked   = (state == LOCKED);

`ifdef VGA_MON_CNT_CHECK_EN
    logic [10:0] prev_h, prev_v;
    logic        cnt_vld, cnt_bad;

    always_comb begin
        cnt_bad = 1'b1;
        if (hcount == prev_h + 11'd1)
            cnt_bad = (vcount != prev_v);
        else if (prev_h == HT - 11'd1 && hcount == 11'd0)
            cnt_bad = !((vcount == prev_v + 11'd1) || (prev_v == VT - 11'd1 && vcount == 11'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_h  <= '0;
            prev_v  <= '0;
            cnt_vld <= 1'b0;
        end else begin
            prev_h  <= hcount;
            prev_v  <= vcount;
            cnt_vld <= active;
        end
    end

    assign cnt_det = active && cnt_vld && cnt_bad;
`else
    logic unused_cnt;
    assign unused_cnt = ^{hcount, vcount};
    assign cnt_det    = 1'b0;
`endif

    logic unused_blnk;
    assign unused_blnk = ^{hblnk, vblnk};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        case (state)
            SEARCH: if (vs_rise) begin
                state_n = MEASURE;
                good_n  = '0;
            end
            MEASURE: begin
                if (vs_rise) begin
                    if (frame_err || any_err) begin
                        good_n = '0;
                    end else if (good_cnt + 4'd1 >= LOCK_N) begin
                        good_n  = LOCK_N;
                        state_n = LOCKED;
                    end else begin
                        good_n = good_cnt + 4'd1;
                    end
                end else if (any_err) begin
                    good_n = '0;
                end
            end
            LOCKED: if (any_err) begin
                state_n = MEASURE;
                good_n  = '0;
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            h_meas       <= '0;
            hsw          <= '0;
            v_meas       <= '0;
            vsw          <= '0;
            h_armed      <= 1'b0;
            frame_err    <= 1'b0;
            meas_h_total <= '0;
            meas_v_total <= '0;
            frame_cnt    <= '0;
            err_hlen     <= 1'b0;
            err_hsw      <= 1'b0;
            err_vlen     <= 1'b0;
            err_vsw      <= 1'b0;
            err_cnt      <= 1'b0;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
            if (!active) begin
                h_meas    <= '0;
                hsw       <= '0;
                v_meas    <= '0;
                vsw       <= '0;
                h_armed   <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                h_meas <= hs_rise ? 11'd1 : sat_inc(h_meas);
                if (hs_rise)    hsw <= 11'd1;
                else if (hsync) hsw <= sat_inc(hsw);
                if (hs_rise) h_armed <= 1'b1;
                if (hs_rise && h_armed) meas_h_total <= h_meas;
                if (vs_rise) begin
                    v_meas       <= '0;
                    vsw          <= {10'd0, hs_rise};
                    meas_v_total <= v_next;
                    frame_cnt    <= frame_cnt + 16'd1;
                end else begin
                    v_meas <= v_next;
                    if (hs_rise && vsync) vsw <= sat_inc(vsw);
                end
                frame_err <= vs_rise ? 1'b0 : (frame_err | any_err);
            end
            // A new error wins over a coincident clear.
            err_hlen <= hlen_det | (err_hlen & ~clr);
            err_hsw  <= hsw_det  | (err_hsw  & ~clr);
            err_vlen <= vlen_det | (err_vlen & ~clr);
            err_vsw  <= vsw_det  | (err_vsw  & ~clr);
            err_cnt  <= cnt_det  | (err_cnt  & ~clr);
        end
    end

endmodule
